// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit: opcodes, ALUOp codes,
// mux encodings, state codes and the packed control vector.
package main_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp codes are also consumed by the ALU control decoder
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_OR;
            OP_ANDI: return ALU_AND;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/main_control_outdec.sv
// Combinational output decoder: maps the current state (plus the latched opcode and
// memory handshake) onto the datapath control vector.
module main_control_outdec
    import main_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_rdy,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // PC and IR only load once the fetched word is actually there
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_IEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_alu_op(op_q);
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control FSM: state register, latched opcode, sticky illegal-opcode
// flag and next-state sequencing; outputs come from main_control_outdec.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       illegal_q;
    logic       illegal_d;
    logic       mem_rdy;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // opcode is only trusted while in DECODE; everything after that steers from op_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (illegal_d) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_RTYPE:                           state_d = S_RTEX;
                    OP_BEQ:                             state_d = S_BEQ;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI:  state_d = S_IEX;
                    OP_J:                               state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_RTWB;
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    main_control_outdec u_outdec (
        .state   (state_q),
        .op_q    (op_q),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal_op    = illegal_q;
    assign state         = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-instruction state paths and control
// vectors from a behavioural model, with randomized memory wait cycles and opcodes.
module tb_main_control_fsm;
    import main_control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;
    logic ill_model = 1'b0;

    main_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    // Reference control table, written straight from the per-state control list
    function automatic logic [15:0] expect_ctrl(input state_t s, input logic [5:0] op, input logic rdy);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00;
        logic [2:0] aop = 3'b000;
        case (s)
            S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mr = 1; iod = 1; end
            S_MEMWR:  begin mw = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_RTEX:   begin asa = 1; aop = 3'b010; end
            S_RTWB:   begin rw = 1; rd = 1; end
            S_BEQ:    begin asa = 1; aop = 3'b110; pwc = 1; pcs = 2'b01; end
            S_IEX: begin
                asa = 1; asb = 2'b10;
                if (op == 6'b001101)      aop = 3'b001;
                else if (op == 6'b001100) aop = 3'b011;
                else if (op == 6'b001010) aop = 3'b111;
                else                      aop = 3'b000;
            end
            S_IWB:    rw = 1;
            S_JUMP:   begin pw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    // Runs one instruction end to end; entry and exit are just after a falling edge
    task automatic run_instr(input string name, input logic [5:0] op, input int wait_fetch,
                             input int wait_mem, input bit scramble);
        state_t path[$];
        bit bad = 0;
        path.push_back(S_FETCH);
        path.push_back(S_DECODE);
        case (op)
            6'b100011: begin path.push_back(S_MEMADR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
            6'b101011: begin path.push_back(S_MEMADR); path.push_back(S_MEMWR); end
            6'b000000: begin path.push_back(S_RTEX); path.push_back(S_RTWB); end
            6'b001000, 6'b001101, 6'b001100, 6'b001010: begin path.push_back(S_IEX); path.push_back(S_IWB); end
            6'b000100: path.push_back(S_BEQ);
            6'b000010: path.push_back(S_JUMP);
            default:   bad = 1;
        endcase
        foreach (path[i]) begin
            state_t s = path[i];
            int nwait = (s == S_FETCH) ? wait_fetch :
                        ((s == S_MEMRD) || (s == S_MEMWR)) ? wait_mem : 0;
            bit is_mem = (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
            for (int w = 0; w <= nwait; w++) begin
                logic rdy = is_mem ? (w == nwait) : 1'($urandom);
                logic [15:0] exp_v;
                mem_ready = rdy;
                opcode = ((s == S_FETCH) || (s == S_DECODE) || !scramble) ? op : 6'($urandom);
                exp_v = expect_ctrl(s, op, rdy);
                #1;
                checks++;
                if (state !== 4'(s) || obs !== exp_v || illegal_op !== ill_model) begin
                    errors++;
                    $display("[TB] FAIL %s op=%b step=%0d: state=%0d want %0d ctrl=%h want %h illegal=%b want %b",
                             name, op, i, state, 4'(s), obs, exp_v, illegal_op, ill_model);
                end
                @(negedge clk);
            end
            if (s == S_DECODE && bad) ill_model = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b111111;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_read: got %b want 1", mem_read); end
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_fetch_wr: ir_write=%b pc_write=%b want 1/1", ir_write, pc_write);
        end
        checks++;
        if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal_op); end
        reset = 1'b0;
        ill_model = 1'b0;
    endtask

    task automatic test_lw();
        run_instr("lw", 6'b100011, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait", 6'b100011, 0, 3, 1'b1);
        run_instr("sw_wait", 6'b101011, 2, 2, 1'b1);
    endtask

    task automatic test_alu_ops();
        run_instr("rtype", 6'b000000, 0, 0, 1'b1);
        run_instr("ori",   6'b001101, 0, 0, 1'b1);
        run_instr("slti",  6'b001010, 0, 0, 1'b1);
        run_instr("andi",  6'b001100, 1, 0, 1'b1);
        run_instr("addi",  6'b001000, 0, 0, 1'b1);
    endtask

    task automatic test_branch_jump();
        run_instr("beq", 6'b000100, 0, 0, 1'b1);
        run_instr("j",   6'b000010, 0, 0, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 0, 0, 1'b0);
        run_instr("after_illegal", 6'b000000, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] ops[9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                               6'b001101, 6'b001100, 6'b001010, 6'b000010};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_reset_mid_access();
        state_t seq[4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD};
        foreach (seq[i]) begin
            mem_ready = (seq[i] == S_MEMRD) ? 1'b0 : 1'b1;
            opcode = 6'b100011;
            #1;
            checks++;
            if (state !== 4'(seq[i])) begin
                errors++; $display("[TB] FAIL mid_seq step=%0d: state=%0d want %0d", i, state, 4'(seq[i]));
            end
            if (i < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || reg_write !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset: state=%0d reg_write=%b want 0/0", state, reg_write);
        end
        checks++;
        if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_illegal: got %b want 0", illegal_op); end
        reset = 1'b0;
        ill_model = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'b0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_lw_wait();
        test_alu_ops();
        test_branch_jump();
        test_illegal();
        test_random();
        test_reset_mid_access();
        run_instr("post_reset", 6'b100011, 0, 1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
